// File: rtl/mem_arbiter.sv
// N-port memory arbiter: round-robin request grant, in-order response routing via a tag FIFO.
// Define MEM_ARB_FIXED_PRIO_EN for strict fixed priority (lowest port index wins).
module mem_arbiter #(
    parameter int NUM_PORTS         = 2,
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int CMD_WIDTH         = 2,
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             i_req_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  i_req_addr,
    input  logic [NUM_PORTS*CMD_WIDTH-1:0]   i_req_cmd,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_req_data,
    output logic [NUM_PORTS-1:0]             o_req_ready,
    output logic [NUM_PORTS-1:0]             o_rsp_valid,
    output logic [DATA_WIDTH-1:0]            o_rsp_data,
    input  logic [NUM_PORTS-1:0]             i_rsp_ready,
    output logic                             o_mem_valid,
    output logic [ADDR_WIDTH-1:0]            o_mem_addr,
    output logic [CMD_WIDTH-1:0]             o_mem_cmd,
    output logic [DATA_WIDTH-1:0]            o_mem_data,
    input  logic                             i_mem_ready,
    input  logic                             i_mem_res_valid,
    input  logic [DATA_WIDTH-1:0]            i_mem_data,
    output logic                             o_mem_res_ready,
    output logic                             o_err_unexpected
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DW = $clog2(OUTSTANDING_DEPTH);
    localparam int CW = DW + 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] tag_mem [OUTSTANDING_DEPTH];
    logic [DW-1:0] rd_ptr;
    logic [DW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          err;

    logic [PW-1:0] winner;
    logic [PW-1:0] cand;
    logic [PW-1:0] head;
    logic          any_valid;
    logic          full;
    logic          empty;
    logic          grant_ok;
    logic          accept;
    logic          pop;

    assign full  = (count == CW'(OUTSTANDING_DEPTH));
    assign empty = (count == '0);
    assign head  = tag_mem[rd_ptr];

    // Rotating search starting at rr_ptr; rr_ptr is pinned to 0 in the fixed-priority build.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!any_valid && i_req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign grant_ok    = !reset && any_valid && !full;
    assign o_mem_valid = grant_ok;
    assign accept      = grant_ok && i_mem_ready;
    assign o_mem_addr  = i_req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign o_mem_cmd   = i_req_cmd[int'(winner)*CMD_WIDTH +: CMD_WIDTH];
    assign o_mem_data  = i_req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];

    assign o_rsp_data  = i_mem_data;
    assign pop         = !reset && i_mem_res_valid && !empty && i_rsp_ready[head];

    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        if (grant_ok) begin
            o_req_ready[winner] = i_mem_ready;
        end
        if (!reset && i_mem_res_valid && !empty) begin
            o_rsp_valid[head] = 1'b1;
        end
    end

    // Responses with nothing outstanding are swallowed so memory never stalls on them.
    assign o_mem_res_ready  = reset ? 1'b0 : (empty ? 1'b1 : i_rsp_ready[head]);
    assign o_err_unexpected = !reset && err;

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + DW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DW'(1);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (i_mem_res_valid && empty) begin
                err <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + PW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of grant order and response routing.
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*CW-1:0] req_cmd;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [N-1:0]    rsp_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic [CW-1:0]   mem_cmd;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready;
    logic            mem_res_valid;
    logic [DW-1:0]   mem_rdata;
    logic            mem_res_ready;
    logic            err_unexpected;

    int tests = 0;
    int fails = 0;

    // Reference model: expected port order of outstanding responses,
    // next round-robin start port, and the sticky error flag.
    int tagq[$];
    int rr    = 0;
    bit err_m = 1'b0;
    int acc_port;

    mem_arbiter #(
        .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CMD_WIDTH(CW), .OUTSTANDING_DEPTH(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req_valid(req_valid),
        .i_req_addr(req_addr),
        .i_req_cmd(req_cmd),
        .i_req_data(req_data),
        .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid),
        .o_rsp_data(rsp_data),
        .i_rsp_ready(rsp_ready),
        .o_mem_valid(mem_valid),
        .o_mem_addr(mem_addr),
        .o_mem_cmd(mem_cmd),
        .o_mem_data(mem_wdata),
        .i_mem_ready(mem_ready),
        .i_mem_res_valid(mem_res_valid),
        .i_mem_data(mem_rdata),
        .o_mem_res_ready(mem_res_ready),
        .o_err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [AW-1:0] a,
                           input logic [CW-1:0] c, input logic [DW-1:0] d);
        req_valid[p]           = 1'b1;
        req_addr[p*AW +: AW]   = a;
        req_cmd[p*CW +: CW]    = c;
        req_data[p*DW +: DW]   = d;
    endtask

    task automatic idle();
        req_valid     = '0;
        mem_ready     = 1'b1;
        mem_res_valid = 1'b0;
        rsp_ready     = '1;
    endtask

    // One clock: predict, compare at negedge, then advance the model.
    task automatic step();
        int           win;
        bit           full;
        logic [N-1:0] e_rr;
        logic [N-1:0] e_rv;
        logic         e_mv;
        logic         e_mrr;
        win  = -1;
        full = (tagq.size() == D);
        for (int i = 0; i < N; i++) begin
            int p;
`ifdef MEM_ARB_FIXED_PRIO_EN
            p = i;
`else
            p = (rr + i) % N;
`endif
            if (win < 0 && req_valid[p]) win = p;
        end
        e_mv = (win >= 0) && !full;
        e_rr = '0;
        if (e_mv && mem_ready) e_rr[win] = 1'b1;
        e_rv = '0;
        if (mem_res_valid && tagq.size() > 0) e_rv[tagq[0]] = 1'b1;
        e_mrr = (tagq.size() == 0) ? 1'b1 : rsp_ready[tagq[0]];
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(e_rr));
        check("mem_valid", 64'(mem_valid), 64'(e_mv));
        check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        check("mem_res_ready", 64'(mem_res_ready), 64'(e_mrr));
        check("err", 64'(err_unexpected), 64'(err_m));
        if (e_mv) begin
            check("mem_addr", 64'(mem_addr), 64'(req_addr[win*AW +: AW]));
            check("mem_cmd", 64'(mem_cmd), 64'(req_cmd[win*CW +: CW]));
            check("mem_data", 64'(mem_wdata), 64'(req_data[win*DW +: DW]));
        end
        if (e_rv != '0) begin
            check("rsp_data", 64'(rsp_data), 64'(mem_rdata));
        end
        @(posedge clk);
        #1;
        acc_port = -1;
        if (mem_res_valid && tagq.size() == 0) begin
            err_m = 1'b1;
        end else if (mem_res_valid && rsp_ready[tagq[0]]) begin
            void'(tagq.pop_front());
        end
        if (e_mv && mem_ready) begin
            tagq.push_back(win);
            rr       = (win + 1) % N;
            acc_port = win;
        end
    endtask

    // Reset held for one clock with busy inputs: every output must read 0.
    task automatic do_reset();
        reset         = 1'b1;
        req_valid     = '1;
        mem_ready     = 1'b1;
        mem_res_valid = 1'b1;
        rsp_ready     = '1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_mem_res_ready", 64'(mem_res_ready), 64'(0));
        check("rst_err", 64'(err_unexpected), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        tagq.delete();
        rr    = 0;
        err_m = 1'b0;
        idle();
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < 2 * D && tagq.size() > 0; k++) begin
            mem_res_valid = 1'b1;
            mem_rdata     = $urandom;
            step();
        end
        mem_res_valid = 1'b0;
        check("drain_empty", 64'(tagq.size()), 64'(0));
    endtask

    initial begin
        req_addr  = '0;
        req_cmd   = '0;
        req_data  = '0;
        mem_rdata = '0;
        idle();
        do_reset();

        // Single read from port 0.
        set_req(0, 32'h100, 2'd0, 32'h0);
        step();
        req_valid     = '0;
        mem_res_valid = 1'b1;
        mem_rdata     = 32'hDEADBEEF;
        rsp_ready     = 2'b01;
        step();
        mem_res_valid = 1'b0;
        rsp_ready     = '0;
        step();
        check("single_empty", 64'(mem_res_ready), 64'(1));

        // Both ports requesting every cycle with responses drained.
        rsp_ready = '1;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 32'h1000 + 32'(k), 2'd0, 32'(k));
            set_req(1, 32'h2000 + 32'(k), 2'd1, 32'(k));
            mem_res_valid = (tagq.size() > 0);
            mem_rdata     = $urandom;
            step();
        end
        drain();

        // Fill the tag FIFO, then pop while full.
        for (int k = 0; k < D + 1; k++) begin
            set_req(0, 32'h300 + 32'(k), 2'd0, 32'h0);
            step();
        end
        check("full_depth", 64'(tagq.size()), 64'(D));
        mem_res_valid = 1'b1;
        mem_rdata     = 32'h1234;
        step();
        mem_res_valid = 1'b0;
        step();
        drain();

        // Response backpressure on port 1.
        set_req(1, 32'h400, 2'd0, 32'h0);
        step();
        req_valid = '0;
        set_req(0, 32'h500, 2'd0, 32'h0);
        step();
        req_valid     = '0;
        mem_res_valid = 1'b1;
        mem_rdata     = 32'hCAFE0001;
        rsp_ready     = 2'b00;
        step();
        step();
        rsp_ready = 2'b10;
        step();
        mem_rdata = 32'hCAFE0002;
        rsp_ready = 2'b01;
        step();
        mem_res_valid = 1'b0;
        rsp_ready     = '1;

        // Random traffic; requesters hold their request until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!req_valid[p] && $urandom_range(0, 99) < 50)
                    set_req(p, $urandom, CW'($urandom), $urandom);
            end
            mem_ready     = ($urandom_range(0, 3) != 0);
            mem_res_valid = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
            rsp_ready     = N'($urandom);
            mem_rdata     = $urandom;
            step();
            if (acc_port >= 0) req_valid[acc_port] = 1'b0;
        end
        idle();
        drain();

        // Unexpected response is consumed and the error sticks.
        mem_res_valid = 1'b1;
        rsp_ready     = '0;
        step();
        mem_res_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Reset with three tags outstanding, then a stale response.
        do_reset();
        mem_res_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(k % 2, 32'h600 + 32'(k), 2'd0, 32'h0);
            step();
            req_valid = '0;
        end
        check("pre_reset_outstanding", 64'(tagq.size()), 64'(3));
        do_reset();
        set_req(0, 32'h700, 2'd0, 32'h0);
        set_req(1, 32'h800, 2'd0, 32'h0);
        mem_ready = 1'b0;
        rsp_ready = '0;
        step();
        req_valid     = '0;
        mem_res_valid = 1'b1;
        step();
        mem_res_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-requester arbiter in front of the single `memory` instance; generalises the one-fetch-port memory hookup in the cpu top.
- Lets fetch, memory_stage and later requesters share one memory: round-robin grant on the request side, in-order response routing back to the issuing port through a tag FIFO.
- Sits between pipeline stages (requesters) and `memory` (downstream).

Parameters:
- NUM_PORTS, 2, number of requester ports (>=2).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, write/read data width.
- CMD_WIDTH, 2, memory command width (MEM_CMD_* encoding).
- OUTSTANDING_DEPTH, 4, max accepted-but-unanswered requests; power of two, >=2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_PORTS  per-port request valid.
- i_req_addr  in  NUM_PORTS*ADDR_WIDTH  flattened addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- i_req_cmd  in  NUM_PORTS*CMD_WIDTH  flattened commands.
- i_req_data  in  NUM_PORTS*DATA_WIDTH  flattened write data.
- o_req_ready  out  NUM_PORTS  per-port accept; one-hot or zero.
- o_rsp_valid  out  NUM_PORTS  per-port response valid; one-hot or zero.
- o_rsp_data  out  DATA_WIDTH  response data, shared by all ports.
- i_rsp_ready  in  NUM_PORTS  per-port response accept.
- o_mem_valid  out  1  to memory i_valid.
- o_mem_addr  out  ADDR_WIDTH  to memory i_address.
- o_mem_cmd  out  CMD_WIDTH  to memory i_cmd.
- o_mem_data  out  DATA_WIDTH  to memory i_data.
- i_mem_ready  in  1  from memory o_ready.
- i_mem_res_valid  in  1  from memory o_res_valid.
- i_mem_data  in  DATA_WIDTH  from memory o_data.
- o_mem_res_ready  out  1  to memory i_res_ready.
- o_err_unexpected  out  1  sticky: response arrived with no outstanding request.

Behaviour:
- State:
  - rr_ptr: $clog2(NUM_PORTS) bits.
  - Tag FIFO: OUTSTANDING_DEPTH entries of port IDs, with rd_ptr, wr_ptr and count.
  - err flag.
- Reset (sync): rr_ptr=0, FIFO empty (count=0, pointers 0), err=0. Outputs settle to o_mem_valid=0, o_req_ready=0, o_rsp_valid=0, o_mem_res_ready=0, o_err_unexpected=0. Reset mid-transaction drops all outstanding tags; later responses are treated as unexpected.
- Grant (combinational):
  - Winner = first p with i_req_valid[p], searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - o_mem_valid = any valid && !full.
  - o_mem_addr/cmd/data = the winner's fields; don't-care when no winner.
- Request handshake: o_req_ready[p] = (p==winner) && i_mem_ready && !full. Accept = o_mem_valid && i_mem_ready.
- On accept:
  - Push winner into the tag FIFO.
  - rr_ptr <= (winner+1) mod NUM_PORTS.
  - No accept means rr_ptr holds.
- Request path is zero-latency; the arbiter adds no cycles.
- Every accepted command (read or write) yields exactly one memory response, in order.
- Response routing (combinational):
  - tag = FIFO head.
  - o_rsp_valid[tag] = i_mem_res_valid && !empty.
  - o_rsp_data = i_mem_data.
  - o_mem_res_ready = empty ? 1 : i_rsp_ready[tag].
- Pop when i_mem_res_valid && !empty && i_rsp_ready[tag].
- Unexpected response: i_mem_res_valid while empty is consumed (ready=1) and sets err; err clears only on reset.
- Full (count==OUTSTANDING_DEPTH): o_mem_valid=0 and all o_req_ready=0, even if a pop happens the same cycle.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pointers wrap modulo OUTSTANDING_DEPTH.
- Requesters must hold valid/addr/cmd/data stable until ready.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN
- Defined: grant is strict fixed priority, lowest port index wins; rr_ptr is not implemented and reads constant 0.
- Undefined: round-robin as above.
- Response routing is identical in both builds.

Test Plan:
- Single requester, NUM_PORTS=2: port 0 reads 0x100, memory returns 0xDEADBEEF -> o_rsp_valid=2'b01, o_rsp_data=0xDEADBEEF; FIFO empty afterward.
- Both ports valid every cycle, i_mem_ready=1, responses drained -> grants alternate 0,1,0,1; no port granted twice in a row. With MEM_ARB_FIXED_PRIO_EN: port 0 granted every cycle.
- Issue 4 requests with responses stalled -> 5th request sees o_req_ready=0 and o_mem_valid=0. Return one response and pop the same cycle -> next cycle accepts again.
- Port 1 i_rsp_ready=0 while its response is valid -> o_mem_res_ready=0 and the FIFO head holds. Raise ready -> pop happens and routing moves to the next tag.
- Response with empty FIFO -> o_mem_res_ready=1, o_err_unexpected goes 1 and stays 1 until reset.
- Reset asserted with 3 tags outstanding -> next cycle all outputs 0, count=0, rr_ptr=0. A stale response afterwards sets o_err_unexpected.
